mem_access_unit: RTL and testbench

- Multi-cycle load/store unit. It replaces the combinational DPI memory path of the single-cycle core with an AXI4-Lite master.
- It accepts one load/store request at a time from the execute stage over a valid/ready handshake. It performs byte-lane alignment, strobe generation and sign/zero extension, then returns the result over a valid/ready response channel.
- Sits between the core datapath (address from ALU, store data from rs2) and the memory/arbiter bus.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 68 ++++++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, AXI response codes
// and the controller state enum.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RSP
    } mem_state_e;

    // Any non-OKAY response (including EXOKAY) is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channels to the execute stage plus the AXI4-Lite master bus.
// Every channel transfers on the cycle where valid and ready are both high at the
// rising edge; valid never waits for ready and its payload holds until the transfer.
interface mem_access_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [XLEN-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    mem_state_e        dbg_state;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid,
        output dbg_state
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid,
        input  dbg_state
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: load extraction with sign/zero extension, store lane
// replication, write strobes and the misalignment check.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [1:0]        size,
    input  logic [OFF_W-1:0]  offset,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   store_data,
    output logic [STRB_W-1:0] strb,
    output logic              misaligned
);

    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   mask;
    logic              sign_bit;
    logic [OFF_W-1:0]  low_mask;
    logic [STRB_W-1:0] strb_base;

    always_comb begin
        shifted    = data >> {offset, 3'b000};
        mask       = '1;
        sign_bit   = shifted[XLEN-1];
        store_data = data;
        strb_base  = '1;
        low_mask   = '1;
        case (size)
            SZ_B: begin
                mask       = XLEN'(8'hFF);
                sign_bit   = shifted[7];
                store_data = {STRB_W{data[7:0]}};
                strb_base  = STRB_W'(1'b1);
                low_mask   = '0;
            end
            SZ_H: begin
                mask       = XLEN'(16'hFFFF);
                sign_bit   = shifted[15];
                store_data = {(XLEN/16){data[15:0]}};
                strb_base  = STRB_W'(2'b11);
                low_mask   = OFF_W'(1);
            end
            SZ_W: begin
                mask       = XLEN'(32'hFFFF_FFFF);
                sign_bit   = shifted[31];
                store_data = {(XLEN/32){data[31:0]}};
                strb_base  = STRB_W'(4'hF);
                low_mask   = OFF_W'(3);
            end
            default: ;
        endcase
        // Bits above the access width are either copies of the sign bit or zero.
        load_data  = (shifted & mask) | ((sign_bit && !is_unsigned) ? ~mask : '0);
        strb       = strb_base << offset;
        misaligned = ((offset & low_mask) != '0) || (size == SZ_D && XLEN == 32);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one request at a time, issued as an AXI4-Lite
// read or write, answered on a registered response channel.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.master bus
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    mem_state_e state_q, state_n;

    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;

    logic              req_ready_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [XLEN-1:0]   rsp_rdata_q, wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              idle, accept, aw_done, w_done, misaligned;
    logic [1:0]        al_size;
    logic [OFF_W-1:0]  al_off;
    logic [XLEN-1:0]   al_data, load_data, store_data;
    logic [STRB_W-1:0] strb;

    assign idle    = (state_q == IDLE);
    assign accept  = idle && bus.req_valid;
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q || bus.wready;

    // One aligner serves both ends: the incoming request while idle, the read beat afterwards.
    assign al_size = idle ? bus.req_size : size_q;
    assign al_off  = idle ? bus.req_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign al_data = idle ? bus.req_wdata : bus.rdata;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .size        (al_size),
        .offset      (al_off),
        .is_unsigned (uns_q),
        .data        (al_data),
        .load_data   (load_data),
        .store_data  (store_data),
        .strb        (strb),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned)      state_n = RSP;
                    else if (bus.req_we) state_n = WR_REQ;
                    else                 state_n = RD_ADDR;
                end
            end
            RD_ADDR: if (bus.arready)       state_n = RD_DATA;
            RD_DATA: if (bus.rvalid)        state_n = RSP;
            WR_REQ:  if (aw_done && w_done) state_n = WR_RESP;
            WR_RESP: if (bus.bvalid)        state_n = RSP;
            RSP:     if (bus.rsp_ready)     state_n = IDLE;
            default:                        state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_B;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            // Handshake outputs are decoded from the next state so they are pure flops.
            req_ready_q <= (state_n == IDLE);
            arvalid_q   <= (state_n == RD_ADDR);
            rready_q    <= (state_n == RD_DATA);
            bready_q    <= (state_n == WR_RESP);
            rsp_valid_q <= (state_n == RSP);

            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= store_data;
                wstrb_q <= strb;
            end

            if (accept && !misaligned && bus.req_we) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else if (state_q == WR_REQ) begin
                if (bus.awready) awvalid_q <= 1'b0;
                if (bus.wready)  wvalid_q  <= 1'b0;
            end

            if (accept && misaligned) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end else if (state_q == RD_DATA && bus.rvalid) begin
                rsp_err_q   <= resp_is_err(bus.rresp);
                rsp_rdata_q <= resp_is_err(bus.rresp) ? '0 : load_data;
            end else if (state_q == WR_RESP && bus.bvalid) begin
                rsp_err_q   <= resp_is_err(bus.bresp);
                rsp_rdata_q <= '0;
            end else if (state_q == RSP && bus.rsp_ready) begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.araddr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.awaddr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.awvalid   = awvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;
    assign bus.dbg_state = state_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner cases and
// randomized transactions against a byte-level reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();
    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly, hold;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        logic        e_bus;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          ar_cyc, aw_cyc, w_cyc, b_entries;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        stable, ready_after, timeout;
    } res_t;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.req_size = 0; bus.req_unsigned = 0; bus.rsp_ready = 0;
        bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;
    endtask

    // Reference: byte arithmetic straight from the access rules.
    task automatic model(input vec_t v, output logic [31:0] e_rdata, output logic e_err,
                         output logic [31:0] e_wdata, output logic [3:0] e_strb, output logic e_mis);
        int n;
        int off;
        longint unsigned val;
        n = 1 << v.size;
        off = int'(v.addr % 4);
        e_mis = (v.size == 2'd3) || (v.addr % n != 0);
        for (int i = 0; i < 4; i++) begin
            e_wdata[8*i +: 8] = v.wd[8*(i % n) +: 8];
            e_strb[i] = (i >= off) && (i < off + n);
        end
        val = longint'(v.rd) >> (8 * off);
        val = val % (64'd1 << (8 * n));
        if (!v.uns && val >= (64'd1 << (8 * n - 1))) val = val - (64'd1 << (8 * n));
        e_err = e_mis || (v.resp != 2'd0);
        e_rdata = (v.we || e_err) ? 32'h0 : val[31:0];
    endtask

    task automatic run_txn(input vec_t v, output res_t r);
        int c, r_at, b_at, aw_hs, w_hs;
        logic r_done, b_done, prev_bready;
        r = '{default: '0};
        r_at = -1; b_at = -1; aw_hs = -1; w_hs = -1;
        r_done = 0; b_done = 0; prev_bready = 0;
        check("accept_req_ready", bus.req_ready, 1);
        bus.req_valid = 1; bus.req_we = v.we; bus.req_addr = v.addr;
        bus.req_wdata = v.wd; bus.req_size = v.size; bus.req_unsigned = v.uns;
        c = 0;
        while (!bus.rsp_valid && c <= 40) begin
            if (bus.arvalid) begin
                r.ar_cyc++; r.addr = bus.araddr;
                bus.arready = (r.ar_cyc > v.ar_dly);
                if (bus.arready) r_at = c + 1 + v.r_dly;
            end else bus.arready = 0;
            bus.rvalid = (r_at >= 0) && (c >= r_at) && !r_done;
            bus.rdata = bus.rvalid ? v.rd : 32'h0;
            bus.rresp = bus.rvalid ? v.resp : 2'b00;
            if (bus.rvalid && bus.rready) r_done = 1;
            if (bus.awvalid) begin
                r.aw_cyc++; r.addr = bus.awaddr;
                bus.awready = (r.aw_cyc > v.aw_dly);
                if (bus.awready) aw_hs = c;
            end else bus.awready = 0;
            if (bus.wvalid) begin
                r.w_cyc++; r.wdata = bus.wdata; r.strb = bus.wstrb;
                bus.wready = (r.w_cyc > v.w_dly);
                if (bus.wready) w_hs = c;
            end else bus.wready = 0;
            if (b_at < 0 && aw_hs >= 0 && w_hs >= 0) b_at = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + v.b_dly;
            bus.bvalid = (b_at >= 0) && (c >= b_at) && !b_done;
            bus.bresp = bus.bvalid ? v.resp : 2'b00;
            if (bus.bvalid && bus.bready) b_done = 1;
            if (bus.bready && !prev_bready) r.b_entries++;
            prev_bready = bus.bready;
            @(posedge clk); #1;
            c++;
            bus.req_valid = 0;
        end
        r.timeout = !bus.rsp_valid;
        r.lat = c;
        bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        r.rdata = bus.rsp_rdata;
        r.err = bus.rsp_err;
        r.stable = bus.rsp_valid && !bus.req_ready;
        repeat (v.hold) begin
            @(posedge clk); #1;
            if (!(bus.rsp_valid && !bus.req_ready && bus.rsp_rdata == r.rdata && bus.rsp_err == r.err))
                r.stable = 0;
        end
        bus.rsp_ready = 1;
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        r.ready_after = bus.req_ready && !bus.rsp_valid;
    endtask

    task automatic check_result(input string tag, input vec_t v, input logic [31:0] e_rdata,
                                input logic e_err, input int e_lat, input logic e_bus,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [3:0] e_strb, input res_t r);
        check({tag, "_timeout"}, r.timeout, 0);
        check({tag, "_rdata"}, r.rdata, e_rdata);
        check({tag, "_err"}, r.err, e_err);
        check({tag, "_latency"}, r.lat, e_lat);
        check({tag, "_rsp_stable"}, r.stable, 1);
        check({tag, "_ready_after"}, r.ready_after, 1);
        if (e_bus) begin
            check({tag, "_bus_addr"}, r.addr, e_addr);
            if (v.we) begin
                check({tag, "_wdata"}, r.wdata, e_wdata);
                check({tag, "_wstrb"}, r.strb, e_strb);
                check({tag, "_wr_resp_entries"}, r.b_entries, 1);
                check({tag, "_no_read"}, r.ar_cyc, 0);
            end else begin
                check({tag, "_no_write"}, r.aw_cyc + r.w_cyc, 0);
            end
        end else begin
            check({tag, "_no_bus"}, r.ar_cyc + r.aw_cyc + r.w_cyc, 0);
        end
    endtask

    initial begin
        res_t r;
        vec_t v;
        logic [31:0] m_rdata, m_wdata;
        logic [3:0]  m_strb;
        logic        m_err, m_mis;
        int          m_lat;

        //             we    addr          wdata         sz    uns   rdata         resp   ar r aw w b hold  e_rdata       err   lat bus   e_addr        e_wdata       strb
        vecs[0]  = '{1'b0, 32'h8000_0003, 32'h0,        2'd0, 1'b0, 32'h80AB_CDEF, 2'd0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, 32'h8000_0000, 32'h0,        4'h0};
        vecs[1]  = '{1'b0, 32'h8000_0002, 32'h0,        2'd1, 1'b1, 32'h9234_5678, 2'd0, 0, 0, 0, 0, 0, 0, 32'h0000_9234, 1'b0, 3, 1'b1, 32'h8000_0000, 32'h0,        4'h0};
        vecs[2]  = '{1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0,        2'd0, 0, 0, 2, 0, 0, 0, 32'h0,        1'b0, 5, 1'b1, 32'h8000_0000, 32'hBEEF_BEEF, 4'hC};
        vecs[3]  = '{1'b0, 32'h8000_0001, 32'h0,        2'd2, 1'b0, 32'h1111_1111, 2'd0, 0, 0, 0, 0, 0, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0,        32'h0,        4'h0};
        vecs[4]  = '{1'b0, 32'h8000_0004, 32'h0,        2'd2, 1'b0, 32'h1234_5678, 2'd2, 0, 0, 0, 0, 0, 3, 32'h0,        1'b1, 3, 1'b1, 32'h8000_0004, 32'h0,        4'h0};
        vecs[5]  = '{1'b0, 32'h8000_0001, 32'h0,        2'd0, 1'b1, 32'h0000_AB00, 2'd0, 0, 0, 0, 0, 0, 0, 32'h0000_00AB, 1'b0, 3, 1'b1, 32'h8000_0000, 32'h0,        4'h0};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,        2'd1, 1'b0, 32'h1234_8001, 2'd0, 0, 0, 0, 0, 0, 0, 32'hFFFF_8001, 1'b0, 3, 1'b1, 32'h8000_0000, 32'h0,        4'h0};
        vecs[7]  = '{1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,        2'd3, 0, 0, 0, 0, 0, 0, 32'h0,        1'b1, 3, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 4'hF};
        vecs[8]  = '{1'b1, 32'h8000_0001, 32'h0000_005A, 2'd0, 1'b0, 32'h0,        2'd0, 0, 0, 0, 1, 0, 0, 32'h0,        1'b0, 4, 1'b1, 32'h8000_0000, 32'h5A5A_5A5A, 4'h2};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,        2'd3, 1'b0, 32'h0,        2'd0, 0, 0, 0, 0, 0, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0,        32'h0,        4'h0};
        vecs[10] = '{1'b1, 32'h8000_0003, 32'h0000_1234, 2'd1, 1'b0, 32'h0,        2'd0, 0, 0, 0, 0, 0, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0,        32'h0,        4'h0};
        vecs[11] = '{1'b0, 32'h8000_000C, 32'h0,        2'd2, 1'b0, 32'hCAFE_F00D, 2'd0, 1, 2, 0, 0, 0, 1, 32'hCAFE_F00D, 1'b0, 6, 1'b1, 32'h8000_000C, 32'h0,        4'h0};
        vecs[12] = '{1'b0, 32'h8000_0002, 32'h0,        2'd0, 1'b0, 32'h007F_0000, 2'd0, 0, 0, 0, 0, 0, 0, 32'h0000_007F, 1'b0, 3, 1'b1, 32'h8000_0000, 32'h0,        4'h0};

        idle_bus();
        rst = 1'b1;
        #12;
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_ar_aw_w_valid", {bus.arvalid, bus.awvalid, bus.wvalid}, 3'b000);
        check("reset_rready_bready", {bus.rready, bus.bready}, 2'b00);
        check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
        check("reset_wstrb", bus.wstrb, 4'h0);
        check("reset_state", bus.dbg_state, IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], r);
            check_result($sformatf("vec%0d", i), vecs[i], vecs[i].e_rdata, vecs[i].e_err,
                         vecs[i].e_lat, vecs[i].e_bus, vecs[i].e_addr, vecs[i].e_wdata,
                         vecs[i].e_strb, r);
        end

        // Reset while the read address is stalled on arready.
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h8000_0010;
        bus.req_size = 2'd2; bus.req_unsigned = 0;
        @(posedge clk); #1;
        bus.req_valid = 0;
        check("rst_mid_arvalid_before", bus.arvalid, 1);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_arvalid_async", bus.arvalid, 0);
        check("rst_mid_req_ready_async", bus.req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_after_release", {bus.req_ready, bus.arvalid, bus.rsp_valid}, 3'b100);
        check("rst_mid_state", bus.dbg_state, IDLE);

        for (int i = 0; i < 60; i++) begin
            v = '{default: '0};
            v.we     = 1'($urandom_range(0, 1));
            v.addr   = 32'h8000_0000 + $urandom_range(0, 31);
            v.wd     = $urandom;
            v.size   = 2'($urandom_range(0, 3));
            v.uns    = 1'($urandom_range(0, 1));
            v.rd     = $urandom;
            v.resp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.ar_dly = $urandom_range(0, 2);
            v.r_dly  = $urandom_range(0, 2);
            v.aw_dly = $urandom_range(0, 2);
            v.w_dly  = $urandom_range(0, 2);
            v.b_dly  = $urandom_range(0, 2);
            v.hold   = $urandom_range(0, 2);
            model(v, m_rdata, m_err, m_wdata, m_strb, m_mis);
            if (m_mis)     m_lat = 1;
            else if (v.we) m_lat = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
            else           m_lat = 3 + v.ar_dly + v.r_dly;
            exp_q.push_back(m_rdata);
            run_txn(v, r);
            check_result($sformatf("rnd%0d", i), v, exp_q.pop_front(), m_err, m_lat, !m_mis,
                         v.addr & 32'hFFFF_FFFC, m_wdata, m_strb, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
